axi_raddr_ch: RTL and testbench
===============================

# axi_raddr_ch

Read-address channel of the AXI RAB MMU. It accepts AR requests from the app/interconnect and translates each virtual address through a small segment table. A translated request is forwarded to the memory controller. A request that faults is never forwarded; instead it gets a locally generated error read response for the response merge in front of `axi_rdata_ch`. The block also throttles the number of reads outstanding in memory.

## Interface
- `ADDR_WID`, 32, virtual/physical address width
- `ID_WID`, 8, AXI ID width
- `USER_WID`, 2, AXI user width
- `DATA_WID`, 32, width of zero data on fault beats
- `SEG_NUM`, 4, segment table entries
- `SEG_IDX_WID`, 2, clog2(`SEG_NUM`)
- `MAX_OUTST`, 16, maximum reads outstanding at the memory controller
- `clk` in 1: the single clock
- `reset` in 1: asynchronous, active-high
- `cfg_we` in 1: segment table write strobe
- `cfg_idx` in `SEG_IDX_WID`: entry to write
- `cfg_valid` in 1: entry enable
- `cfg_vbase` in `ADDR_WID`: segment virtual base
- `cfg_vlimit` in `ADDR_WID`: exclusive virtual limit
- `cfg_pbase` in `ADDR_WID`: segment physical base
- `in_arid` / `in_araddr` / `in_arlen[7:0]` / `in_arsize[2:0]` / `in_arburst[1:0]` / `in_aruser` in: app AR fields
- `in_arvalid` in 1, `out_arready` out 1: app AR handshake
- `out_arid` / `out_araddr` / `out_arlen` / `out_arsize` / `out_arburst` / `out_aruser` out: memory AR fields (registered)
- `out_marvalid` out 1, `in_marready` in 1: memory AR handshake
- `out_fid` / `out_fdata` / `out_fresp[1:0]` / `out_fuser` / `out_flast` out: fault response beat (registered)
- `out_fvalid` out 1, `in_fready` in 1: fault response handshake
- `in_rdone` in 1: one-cycle pulse per completed memory burst (rlast handshake on the rdata side)
- `out_outst` out clog2(`MAX_OUTST`+1): current outstanding count

## Operation
- **States:**
  - IDLE: `out_arready` = (count < `MAX_OUTST`). On AR handshake, latch all fields and go to XLATE.
  - XLATE: run the lookup.
    - Hit with supported burst: load the memory AR registers and go to ISSUE.
    - Otherwise: load the first fault beat, load the beat counter = `arlen`, and go to FAULT.
  - ISSUE: hold `out_marvalid` = 1 with stable fields. On `in_marready`, count += 1 and return to IDLE.
  - FAULT: hold `out_fvalid` = 1. On each `in_fready`:
    - If beat counter == 0, return to IDLE with `out_fvalid` = 0.
    - Otherwise decrement the counter and present the next beat.
- **Lookup:**
  - span = FIXED ? (1 << arsize) : (arlen + 1) << arsize.
  - end = araddr + span, computed in `ADDR_WID`+1 bits.
  - Entry i hits if valid & vbase ≤ araddr & end ≤ vlimit & no carry out of the end sum.
  - If several entries hit, the lowest index wins.
  - Physical address = araddr − vbase + pbase, modulo 2^`ADDR_WID`.
- **Fault codes:**
  - `in_arburst` = 2'b11 (reserved) or 2'b10 (WRAP): SLVERR (2'b10).
  - No hit or carry-out: DECERR (2'b11).
  - Burst check has priority over the lookup.
- **Fault beats:**
  - arlen+1 beats.
  - `out_fid`/`out_fuser` are the latched values; `out_fdata` = 0.
  - `out_flast` = 1 only on the final beat.
- **Outstanding counter:**
  - Increments on the memory AR handshake and decrements on `in_rdone`; both in the same cycle leave it unchanged.
  - `in_rdone` at count 0 is ignored (no wrap).
  - Fault requests never touch the counter.
- **Config writes** take effect at the clock edge. A lookup in the same cycle as a write sees the old contents. Writes are legal in any state.

## Timing
- Reset (async): state IDLE, all table entries invalid, count 0, and every output 0, including `out_arready` (it rises in the first cycle after reset release).
- AR handshake at cycle 0 → XLATE at cycle 1 → `out_marvalid` or `out_fvalid` high from cycle 2.
  - Minimum issue interval: 3 cycles per request, plus back-pressure.
- `out_arready` is 0 in every state except IDLE; one request is in flight in the block at a time.
- While VALID is held without READY, the outputs stay stable; VALID never drops before its handshake.
- Fault beats issue back to back: one per cycle while `in_fready` = 1.
- Reset asserted mid-burst or mid-issue aborts immediately. No partial beats are resumed.

## Structure
- Package `axi_rab_pkg` holds:
  - `RESP_OKAY` / `RESP_SLVERR` / `RESP_DECERR` constants;
  - `BURST_FIXED` / `BURST_INCR` / `BURST_WRAP` constants;
  - the state enum;
  - the `seg_entry_t` struct (valid, vbase, vlimit, pbase).
- Sub-module `rab_seg_lookup` is purely combinational: it takes the table, araddr and end, and produces hit, index, carry and paddr. It is reusable by the write-address channel.

## Test plan
- Segment 0 = {vbase 0x1000, vlimit 0x2000, pbase 0x8000_0000}; AR addr 0x1100, len 3, size 2, INCR → `out_araddr` 0x8000_0100 at cycle 2, `out_outst` 1 after `in_marready`.
- AR addr 0x1FF8, len 3, size 2 (end 0x2008 > limit) → 4 DECERR beats with the ID echoed, `flast` only on beat 4, count unchanged.
- `in_arburst` 2'b11 with an address that hits → 1+len SLVERR beats; WRAP is likewise SLVERR.
- Issue 16 reads without `in_rdone` → `out_arready` stays 0. A `in_rdone` pulse coincident with the 17th attempt → `out_arready` = 1 in the next IDLE cycle.
- Pulse `in_rdone` in the same cycle as `in_marready` with count 5 → count remains 5. `in_rdone` at count 0 → remains 0.
- Assert `reset` during FAULT beat 2 of 4 → `out_fvalid` = 0 at once, table invalid, and the next AR faults DECERR.

Source files
------------

// File: rtl/axi_raddr_ch_pkg.sv
// Shared types and constants for the RAB MMU address channels.
// Holds response/burst codes, channel states and segment entries.
package axi_rab_pkg;

  localparam int RAB_ADDR_WID = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XLATE,
    ST_ISSUE,
    ST_FAULT
  } rd_state_e;

  typedef struct packed {
    logic                    valid;
    logic [RAB_ADDR_WID-1:0] vbase;
    logic [RAB_ADDR_WID-1:0] vlimit;
    logic [RAB_ADDR_WID-1:0] pbase;
  } seg_entry_t;

  // Only FIXED and INCR bursts are translated; WRAP and reserved fault.
  function automatic logic burst_ok(input logic [1:0] b);
    return (b == BURST_FIXED) || (b == BURST_INCR);
  endfunction

endpackage

// File: rtl/axi_raddr_ch_if.sv
// Bus bundle of the read-address channel: config, app AR, memory AR,
// fault response and completion/outstanding signals.
interface axi_raddr_ch_if #(
  parameter int ADDR_WID    = 32,
  parameter int ID_WID      = 8,
  parameter int USER_WID    = 2,
  parameter int DATA_WID    = 32,
  parameter int SEG_IDX_WID = 2,
  parameter int CNT_WID     = 5
);

  logic                   cfg_we;
  logic [SEG_IDX_WID-1:0] cfg_idx;
  logic                   cfg_valid;
  logic [ADDR_WID-1:0]    cfg_vbase;
  logic [ADDR_WID-1:0]    cfg_vlimit;
  logic [ADDR_WID-1:0]    cfg_pbase;

  logic [ID_WID-1:0]      in_arid;
  logic [ADDR_WID-1:0]    in_araddr;
  logic [7:0]             in_arlen;
  logic [2:0]             in_arsize;
  logic [1:0]             in_arburst;
  logic [USER_WID-1:0]    in_aruser;
  logic                   in_arvalid;
  logic                   out_arready;

  logic [ID_WID-1:0]      out_arid;
  logic [ADDR_WID-1:0]    out_araddr;
  logic [7:0]             out_arlen;
  logic [2:0]             out_arsize;
  logic [1:0]             out_arburst;
  logic [USER_WID-1:0]    out_aruser;
  logic                   out_marvalid;
  logic                   in_marready;

  logic [ID_WID-1:0]      out_fid;
  logic [DATA_WID-1:0]    out_fdata;
  logic [1:0]             out_fresp;
  logic [USER_WID-1:0]    out_fuser;
  logic                   out_flast;
  logic                   out_fvalid;
  logic                   in_fready;

  logic                   in_rdone;
  logic [CNT_WID-1:0]     out_outst;

  modport slave (
    input  cfg_we, cfg_idx, cfg_valid, cfg_vbase, cfg_vlimit, cfg_pbase,
    input  in_arid, in_araddr, in_arlen, in_arsize, in_arburst,
    input  in_aruser, in_arvalid,
    output out_arready,
    output out_arid, out_araddr, out_arlen, out_arsize, out_arburst,
    output out_aruser, out_marvalid,
    input  in_marready,
    output out_fid, out_fdata, out_fresp, out_fuser, out_flast,
    output out_fvalid,
    input  in_fready, in_rdone,
    output out_outst
  );

  modport master (
    output cfg_we, cfg_idx, cfg_valid, cfg_vbase, cfg_vlimit, cfg_pbase,
    output in_arid, in_araddr, in_arlen, in_arsize, in_arburst,
    output in_aruser, in_arvalid,
    input  out_arready,
    input  out_arid, out_araddr, out_arlen, out_arsize, out_arburst,
    input  out_aruser, out_marvalid,
    output in_marready,
    input  out_fid, out_fdata, out_fresp, out_fuser, out_flast,
    input  out_fvalid,
    output in_fready, in_rdone,
    input  out_outst
  );

endinterface

// File: rtl/axi_raddr_ch_seg_lookup.sv
// Combinational segment-table lookup, shared by the AR and AW channels.
// Lowest-index hit wins; paddr is relative to the winning segment.
module rab_seg_lookup
  import axi_rab_pkg::*;
#(
  parameter int ADDR_WID    = RAB_ADDR_WID,
  parameter int SEG_NUM     = 4,
  parameter int SEG_IDX_WID = 2
) (
  input  seg_entry_t [SEG_NUM-1:0] tbl_i,
  input  logic [ADDR_WID-1:0]      addr_i,
  input  logic [ADDR_WID:0]        end_i,
  output logic                     hit_o,
  output logic [SEG_IDX_WID-1:0]   idx_o,
  output logic                     carry_o,
  output logic [ADDR_WID-1:0]      paddr_o
);

  // Scan high to low so the lowest matching index is the last writer.
  always_comb begin
    hit_o   = 1'b0;
    idx_o   = '0;
    paddr_o = '0;
    carry_o = end_i[ADDR_WID];
    for (int i = SEG_NUM - 1; i >= 0; i--) begin
      if (tbl_i[i].valid &&
          (tbl_i[i].vbase <= addr_i) &&
          (end_i[ADDR_WID-1:0] <= tbl_i[i].vlimit) &&
          !end_i[ADDR_WID]) begin
        hit_o   = 1'b1;
        idx_o   = SEG_IDX_WID'(i);
        paddr_o = addr_i - tbl_i[i].vbase + tbl_i[i].pbase;
      end
    end
  end

endmodule

// File: rtl/axi_raddr_ch.sv
// Read-address channel of the RAB MMU: translates AR requests, forwards
// hits to memory, answers faults locally, throttles outstanding reads.
module axi_raddr_ch
  import axi_rab_pkg::*;
#(
  parameter int ADDR_WID    = RAB_ADDR_WID,
  parameter int ID_WID      = 8,
  parameter int USER_WID    = 2,
  parameter int DATA_WID    = 32,
  parameter int SEG_NUM     = 4,
  parameter int SEG_IDX_WID = 2,
  parameter int MAX_OUTST   = 16
) (
  input logic           clk,
  input logic           reset,
  axi_raddr_ch_if.slave bus
);

  localparam int CNT_WID = $clog2(MAX_OUTST + 1);
  localparam int AW1     = ADDR_WID + 1;
  localparam logic [CNT_WID-1:0] CNT_MAX = CNT_WID'(MAX_OUTST);

  rd_state_e state_q, state_d;

  seg_entry_t [SEG_NUM-1:0] tbl_q;

  logic [ID_WID-1:0]   id_q, id_d;
  logic [ADDR_WID-1:0] addr_q, addr_d;
  logic [7:0]          len_q, len_d;
  logic [2:0]          size_q, size_d;
  logic [1:0]          burst_q, burst_d;
  logic [USER_WID-1:0] user_q, user_d;

  logic [ADDR_WID-1:0] maddr_q, maddr_d;
  logic                mvalid_q, mvalid_d;

  logic [1:0]          fresp_q, fresp_d;
  logic                flast_q, flast_d;
  logic                fvalid_q, fvalid_d;
  logic [7:0]          beat_q, beat_d;

  logic [CNT_WID-1:0]  cnt_q, cnt_d;
  logic                arready_q, arready_d;

  logic [AW1-1:0]         span;
  logic [AW1-1:0]         end_sum;
  logic                   lk_hit;
  logic                   lk_carry;
  logic                   lk_ok;
  logic [SEG_IDX_WID-1:0] lk_idx;
  logic [ADDR_WID-1:0]    lk_paddr;
  logic                   inc;
  logic                   dec;

  // Byte span of the latched burst and its exclusive end address.
  always_comb begin
    if (burst_q == BURST_FIXED) begin
      span = AW1'(1) << size_q;
    end else begin
      span = (AW1'(len_q) + AW1'(1)) << size_q;
    end
    end_sum = {1'b0, addr_q} + span;
  end

  rab_seg_lookup #(
    .ADDR_WID    (ADDR_WID),
    .SEG_NUM     (SEG_NUM),
    .SEG_IDX_WID (SEG_IDX_WID)
  ) u_lookup (
    .tbl_i   (tbl_q),
    .addr_i  (addr_q),
    .end_i   (end_sum),
    .hit_o   (lk_hit),
    .idx_o   (lk_idx),
    .carry_o (lk_carry),
    .paddr_o (lk_paddr)
  );

  assign lk_ok = lk_hit && !lk_carry && tbl_q[lk_idx].valid;

  // Outstanding count: issue and completion in one cycle cancel out.
  always_comb begin
    inc   = mvalid_q && bus.in_marready;
    dec   = bus.in_rdone && (cnt_q != '0);
    cnt_d = cnt_q;
    if (inc && !dec) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec && !inc) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Next state, field latching, issue and fault-beat sequencing.
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    addr_d   = addr_q;
    len_d    = len_q;
    size_d   = size_q;
    burst_d  = burst_q;
    user_d   = user_q;
    maddr_d  = maddr_q;
    mvalid_d = mvalid_q;
    fresp_d  = fresp_q;
    flast_d  = flast_q;
    fvalid_d = fvalid_q;
    beat_d   = beat_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_arvalid && arready_q) begin
          id_d    = bus.in_arid;
          addr_d  = bus.in_araddr;
          len_d   = bus.in_arlen;
          size_d  = bus.in_arsize;
          burst_d = bus.in_arburst;
          user_d  = bus.in_aruser;
          state_d = ST_XLATE;
        end
      end
      ST_XLATE: begin
        if (burst_ok(burst_q) && lk_ok) begin
          maddr_d  = lk_paddr;
          mvalid_d = 1'b1;
          state_d  = ST_ISSUE;
        end else begin
          fresp_d  = burst_ok(burst_q) ? RESP_DECERR : RESP_SLVERR;
          fvalid_d = 1'b1;
          flast_d  = (len_q == 8'd0);
          beat_d   = len_q;
          state_d  = ST_FAULT;
        end
      end
      ST_ISSUE: begin
        if (bus.in_marready) begin
          mvalid_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      ST_FAULT: begin
        if (bus.in_fready) begin
          if (beat_q == 8'd0) begin
            fvalid_d = 1'b0;
            flast_d  = 1'b0;
            state_d  = ST_IDLE;
          end else begin
            beat_d  = beat_q - 8'd1;
            flast_d = (beat_q == 8'd1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    arready_d = (state_d == ST_IDLE) && (cnt_d < CNT_MAX);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latched request, memory AR and fault-beat registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      user_q    <= '0;
      maddr_q   <= '0;
      mvalid_q  <= 1'b0;
      fresp_q   <= RESP_OKAY;
      flast_q   <= 1'b0;
      fvalid_q  <= 1'b0;
      beat_q    <= '0;
      arready_q <= 1'b0;
    end else begin
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      user_q    <= user_d;
      maddr_q   <= maddr_d;
      mvalid_q  <= mvalid_d;
      fresp_q   <= fresp_d;
      flast_q   <= flast_d;
      fvalid_q  <= fvalid_d;
      beat_q    <= beat_d;
      arready_q <= arready_d;
    end
  end

  // Outstanding-read counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Segment table; a lookup in the write cycle still sees old contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tbl_q <= '0;
    end else if (bus.cfg_we) begin
      tbl_q[bus.cfg_idx] <= '{
        valid:  bus.cfg_valid,
        vbase:  bus.cfg_vbase,
        vlimit: bus.cfg_vlimit,
        pbase:  bus.cfg_pbase
      };
    end
  end

  assign bus.out_arready  = arready_q;
  assign bus.out_arid     = id_q;
  assign bus.out_araddr   = maddr_q;
  assign bus.out_arlen    = len_q;
  assign bus.out_arsize   = size_q;
  assign bus.out_arburst  = burst_q;
  assign bus.out_aruser   = user_q;
  assign bus.out_marvalid = mvalid_q;
  assign bus.out_fid      = id_q;
  assign bus.out_fdata    = {DATA_WID{1'b0}};
  assign bus.out_fresp    = fresp_q;
  assign bus.out_fuser    = user_q;
  assign bus.out_flast    = flast_q;
  assign bus.out_fvalid   = fvalid_q;
  assign bus.out_outst    = cnt_q;

endmodule

// File: tb/tb_axi_raddr_ch.sv
// Bench for axi_raddr_ch: directed scenarios plus random requests
// checked against a byte-range model of the segment table.
module tb_axi_raddr_ch;
  import axi_rab_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  axi_raddr_ch_if bus ();

  axi_raddr_ch dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  bit     m_valid[4];
  longint m_vb[4];
  longint m_vl[4];
  longint m_pb[4];
  int     m_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: translate using whole byte ranges, no carry tricks.
  function automatic void predict(input longint a, input int len,
                                  input int size, input int burst,
                                  output bit fault,
                                  output logic [1:0] resp,
                                  output longint pa);
    longint span;
    longint e;
    fault = 1'b1;
    resp  = 2'b11;
    pa    = 0;
    if (burst >= 2) begin
      resp = 2'b10;
      return;
    end
    if (burst == 0) span = longint'(1) << size;
    else            span = longint'(len + 1) << size;
    e = a + span;
    for (int i = 0; i < 4; i++) begin
      if (m_valid[i] && m_vb[i] <= a && e <= m_vl[i]) begin
        fault = 1'b0;
        resp  = 2'b00;
        pa    = (a - m_vb[i] + m_pb[i]) & 64'hFFFF_FFFF;
        return;
      end
    end
  endfunction

  task automatic cfg_write(input int idx, input bit v, input longint vb,
                           input longint vl, input longint pb);
    bus.cfg_we     = 1'b1;
    bus.cfg_idx    = 2'(idx);
    bus.cfg_valid  = v;
    bus.cfg_vbase  = 32'(vb);
    bus.cfg_vlimit = 32'(vl);
    bus.cfg_pbase  = 32'(pb);
    @(posedge clk);
    @(negedge clk);
    bus.cfg_we  = 1'b0;
    m_valid[idx] = v;
    m_vb[idx]    = vb;
    m_vl[idx]    = vl;
    m_pb[idx]    = pb;
  endtask

  task automatic drive_ar(input longint a, input int len, input int size,
                          input int burst, input int id, input int user);
    bus.in_araddr  = 32'(a);
    bus.in_arlen   = 8'(len);
    bus.in_arsize  = 3'(size);
    bus.in_arburst = 2'(burst);
    bus.in_arid    = 8'(id);
    bus.in_aruser  = 2'(user);
  endtask

  // Handshake one AR; returns at the falling edge of the XLATE cycle.
  task automatic send_ar(input longint a, input int len, input int size,
                         input int burst, input int id, input int user);
    int t = 0;
    while (bus.out_arready !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("ar_ready_wait", bus.out_arready, 1);
    drive_ar(a, len, size, burst, id, user);
    bus.in_arvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_arvalid = 1'b0;
    chk("xlate_ready_low", bus.out_arready, 0);
  endtask

  // From XLATE: check the issued AR or the whole fault burst.
  task automatic check_resp(input longint a, input int len, input int size,
                            input int burst, input int id, input int user,
                            input bit rd);
    bit fault;
    logic [1:0] resp;
    longint pa;
    int pre;
    predict(a, len, size, burst, fault, resp, pa);
    @(negedge clk);
    if (!fault) begin
      chk("issue_mvalid", bus.out_marvalid, 1);
      chk("issue_fvalid", bus.out_fvalid, 0);
      chk("issue_addr", bus.out_araddr, pa);
      chk("issue_id", bus.out_arid, id);
      chk("issue_len", bus.out_arlen, len);
      chk("issue_size", bus.out_arsize, size);
      chk("issue_burst", bus.out_arburst, burst);
      chk("issue_user", bus.out_aruser, user);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        chk("issue_hold_v", bus.out_marvalid, 1);
        chk("issue_hold_a", bus.out_araddr, pa);
      end
      bus.in_marready = 1'b1;
      bus.in_rdone    = rd;
      @(posedge clk);
      pre   = m_cnt;
      m_cnt = pre + 1 - ((rd && pre > 0) ? 1 : 0);
      @(negedge clk);
      bus.in_marready = 1'b0;
      bus.in_rdone    = 1'b0;
      chk("issue_drop", bus.out_marvalid, 0);
      chk("outst_issue", bus.out_outst, m_cnt);
    end else begin
      for (int b = 0; b <= len; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          bus.in_fready = 1'b0;
          @(negedge clk);
          chk("f_hold_v", bus.out_fvalid, 1);
          chk("f_hold_last", bus.out_flast, (b == len));
        end
        chk("f_valid", bus.out_fvalid, 1);
        chk("f_mvalid", bus.out_marvalid, 0);
        chk("f_id", bus.out_fid, id);
        chk("f_user", bus.out_fuser, user);
        chk("f_resp", bus.out_fresp, resp);
        chk("f_data", bus.out_fdata, 0);
        chk("f_last", bus.out_flast, (b == len));
        bus.in_fready = 1'b1;
        @(posedge clk);
        @(negedge clk);
      end
      bus.in_fready = 1'b0;
      chk("f_end", bus.out_fvalid, 0);
      chk("f_outst", bus.out_outst, m_cnt);
    end
  endtask

  task automatic do_ar(input longint a, input int len, input int size,
                       input int burst, input int id, input int user,
                       input bit rd);
    send_ar(a, len, size, burst, id, user);
    check_resp(a, len, size, burst, id, user, rd);
  endtask

  task automatic pulse_rdone();
    bus.in_rdone = 1'b1;
    @(posedge clk);
    if (m_cnt > 0) m_cnt--;
    @(negedge clk);
    bus.in_rdone = 1'b0;
    chk("outst_rdone", bus.out_outst, m_cnt);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    bus.cfg_we = 0; bus.cfg_idx = 0; bus.cfg_valid = 0;
    bus.cfg_vbase = 0; bus.cfg_vlimit = 0; bus.cfg_pbase = 0;
    drive_ar(0, 0, 0, 0, 0, 0);
    bus.in_arvalid = 0; bus.in_marready = 0;
    bus.in_fready = 0; bus.in_rdone = 0;
    for (int i = 0; i < 4; i++) m_valid[i] = 0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_arready", bus.out_arready, 0);
    chk("rst_mvalid", bus.out_marvalid, 0);
    chk("rst_fvalid", bus.out_fvalid, 0);
    chk("rst_outst", bus.out_outst, 0);
    chk("rst_araddr", bus.out_araddr, 0);
    chk("rst_flast", bus.out_flast, 0);
    chk("rst_fresp", bus.out_fresp, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", bus.out_arready, 1);

    // Basic translate, overrun fault, burst-type faults.
    cfg_write(0, 1, 64'h1000, 64'h2000, 64'h8000_0000);
    do_ar(64'h1100, 3, 2, 1, 8'h5A, 1, 0);
    chk("plan_outst1", bus.out_outst, 1);
    do_ar(64'h1FF8, 3, 2, 1, 8'hA5, 2, 0);
    do_ar(64'h1100, 2, 2, 3, 8'h33, 3, 0);
    do_ar(64'h1100, 1, 2, 2, 8'h44, 0, 0);

    // Exact-limit hits, carry-out fault, lowest index wins.
    do_ar(64'h1FFC, 7, 2, 0, 8'h11, 1, 0);
    do_ar(64'h1FF0, 3, 2, 1, 8'h12, 2, 0);
    cfg_write(1, 1, 64'hFFFF_F000, 64'hFFFF_FFFF, 64'h100);
    do_ar(64'hFFFF_FFF8, 3, 2, 1, 8'h13, 0, 0);
    cfg_write(2, 1, 64'h1000, 64'h3000, 64'h4000_0000);
    do_ar(64'h1200, 0, 3, 1, 8'h14, 3, 0);

    // Fill to the outstanding limit.
    guard = 0;
    while (m_cnt < 16 && guard < 40) begin
      do_ar(64'h1000 + (longint'($urandom_range(0, 32'h3C0)) << 2),
            $urandom_range(0, 3), 2, 1, $urandom_range(0, 255),
            $urandom_range(0, 3), 0);
      guard++;
    end
    chk("full_cnt", bus.out_outst, 16);
    drive_ar(64'h1400, 1, 2, 1, 8'h77, 2);
    bus.in_arvalid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("full_noready", bus.out_arready, 0);
      chk("full_nomv", bus.out_marvalid, 0);
    end
    bus.in_rdone = 1'b1;
    @(posedge clk);
    m_cnt--;
    @(negedge clk);
    bus.in_rdone = 1'b0;
    chk("relief_ready", bus.out_arready, 1);
    chk("relief_cnt", bus.out_outst, 15);
    @(posedge clk);
    @(negedge clk);
    bus.in_arvalid = 1'b0;
    check_resp(64'h1400, 1, 2, 1, 8'h77, 2, 0);

    // Coincident issue/completion, and completion at zero.
    while (m_cnt > 5) pulse_rdone();
    do_ar(64'h1800, 2, 2, 1, 8'h55, 1, 1);
    chk("coinc_cnt5", bus.out_outst, 5);
    while (m_cnt > 0) pulse_rdone();
    pulse_rdone();
    chk("zero_cnt", bus.out_outst, 0);

    // Random traffic over a randomly programmed table.
    for (int s = 1; s < 4; s++) begin
      longint vb;
      vb = longint'($urandom_range(0, 32'h5000)) & 64'hFFFF_FF00;
      cfg_write(s, $urandom_range(0, 3) != 0, vb,
                vb + $urandom_range(32'h100, 32'h3000), $urandom);
    end
    for (int n = 0; n < 30; n++) begin
      if (m_cnt >= 12) repeat (4) pulse_rdone();
      do_ar(longint'($urandom_range(0, 32'h7000)) & 64'hFFFF_FFFC,
            $urandom_range(0, 5), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 255),
            $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a fault burst.
    cfg_write(0, 1, 64'h1000, 64'h2000, 64'h8000_0000);
    do_ar(64'h1100, 0, 2, 1, 8'h21, 1, 0);
    send_ar(64'h1100, 3, 2, 3, 8'h22, 2);
    @(negedge clk);
    chk("mid_f_v1", bus.out_fvalid, 1);
    chk("mid_f_resp", bus.out_fresp, 2'b10);
    bus.in_fready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_fready = 1'b0;
    chk("mid_f_v2", bus.out_fvalid, 1);
    reset = 1'b1;
    #1;
    chk("abort_fvalid", bus.out_fvalid, 0);
    chk("abort_flast", bus.out_flast, 0);
    chk("abort_outst", bus.out_outst, 0);
    chk("abort_arready", bus.out_arready, 0);
    for (int i = 0; i < 4; i++) m_valid[i] = 0;
    m_cnt = 0;
    @(negedge clk);
    reset = 1'b0;

    // Empty table faults; a write during XLATE is not yet visible.
    send_ar(64'h1100, 1, 2, 1, 8'h31, 3);
    bus.cfg_we     = 1'b1;
    bus.cfg_idx    = 2'd0;
    bus.cfg_valid  = 1'b1;
    bus.cfg_vbase  = 32'h1000;
    bus.cfg_vlimit = 32'h2000;
    bus.cfg_pbase  = 32'h9000_0000;
    check_resp(64'h1100, 1, 2, 1, 8'h31, 3, 0);
    bus.cfg_we = 1'b0;
    m_valid[0] = 1; m_vb[0] = 64'h1000;
    m_vl[0] = 64'h2000; m_pb[0] = 64'h9000_0000;
    do_ar(64'h1100, 1, 2, 1, 8'h32, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
